// File: rtl/pr_sector_avmm_freeze_bridge.sv
// Avalon-MM bridge between a PR sector's user-logic master and the static NoC slave:
// registered command path, read-outstanding tracking and a drain/isolate freeze handshake.
module pr_sector_avmm_freeze_bridge #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 20,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_req,
    output logic              freeze_ack,
    input  logic              pr_read,
    input  logic              pr_write,
    input  logic [ADDR_W-1:0] pr_address,
    input  logic [DATA_W-1:0] pr_writedata,
    output logic              pr_waitrequest,
    output logic [DATA_W-1:0] pr_readdata,
    output logic              pr_readdatavalid,
    output logic              avmm_master_read,
    output logic              avmm_master_write,
    output logic [ADDR_W-1:0] avmm_master_address,
    output logic [DATA_W-1:0] avmm_master_writedata,
    input  logic              avmm_master_waitrequest,
    input  logic [DATA_W-1:0] avmm_master_readdata,
    input  logic              avmm_master_readdatavalid,
    output logic [CNT_W-1:0]  outstanding,
    output logic              drain_timeout,
    output logic [7:0]        stray_resp_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, FROZEN} state_t;

    state_t            state_reg;
    logic              cmd_valid_reg;
    logic              cmd_rd_reg;
    logic              cmd_wr_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_data_reg;
    logic [CNT_W-1:0]  outstanding_reg;
    logic [TMR_W-1:0]  drain_tmr_reg;
    logic              drain_timeout_reg;
    logic              freeze_ack_reg;
    logic              pr_readdatavalid_reg;
    logic [DATA_W-1:0] pr_readdata_reg;
    logic [7:0]        stray_cnt_reg;

    logic              accept;
    logic              rd_accept;
    logic              consume;
    logic              resp_fwd;
    logic              resp_stray;
    logic              cmd_valid_next;
    logic [CNT_W-1:0]  outstanding_next;

    assign pr_waitrequest = rst | (state_reg != RUN)
                          | (cmd_valid_reg & avmm_master_waitrequest)
                          | (pr_read & (outstanding_reg == OUT_MAX));

    assign accept         = (pr_read | pr_write) & ~pr_waitrequest;
    assign rd_accept      = accept & pr_read;
    assign consume        = cmd_valid_reg & ~avmm_master_waitrequest;
    // A response is only legitimate if a read is owed and the region is not isolated.
    assign resp_fwd       = avmm_master_readdatavalid & (outstanding_reg != '0) & (state_reg != FROZEN);
    assign resp_stray     = avmm_master_readdatavalid & ~resp_fwd;
    assign cmd_valid_next = accept | (cmd_valid_reg & ~consume);

    always_comb begin
        outstanding_next = outstanding_reg;
        if (rd_accept && !resp_fwd) begin
            outstanding_next = outstanding_reg + CNT_W'(1);
        end else if (!rd_accept && resp_fwd) begin
            outstanding_next = outstanding_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= RUN;
            cmd_valid_reg        <= 1'b0;
            cmd_rd_reg           <= 1'b0;
            cmd_wr_reg           <= 1'b0;
            cmd_addr_reg         <= '0;
            cmd_data_reg         <= '0;
            outstanding_reg      <= '0;
            drain_tmr_reg        <= '0;
            drain_timeout_reg    <= 1'b0;
            freeze_ack_reg       <= 1'b0;
            pr_readdatavalid_reg <= 1'b0;
            pr_readdata_reg      <= '0;
            stray_cnt_reg        <= '0;
        end else begin
            cmd_valid_reg        <= cmd_valid_next;
            outstanding_reg      <= outstanding_next;
            pr_readdatavalid_reg <= resp_fwd;
            if (accept) begin
                cmd_rd_reg   <= pr_read;
                cmd_wr_reg   <= ~pr_read;
                cmd_addr_reg <= pr_address;
                cmd_data_reg <= pr_writedata;
            end
            if (resp_fwd) begin
                pr_readdata_reg <= avmm_master_readdata;
            end
            if (resp_stray && stray_cnt_reg != 8'hFF) begin
                stray_cnt_reg <= stray_cnt_reg + 8'd1;
            end

            case (state_reg)
                RUN: begin
                    drain_tmr_reg <= '0;
                    if (freeze_req) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_tmr_reg <= drain_tmr_reg + TMR_W'(1);
                    if (!freeze_req) begin
                        state_reg <= RUN;
                    end else if (!cmd_valid_next && outstanding_next == '0) begin
                        state_reg      <= FROZEN;
                        freeze_ack_reg <= 1'b1;
                    end else if (drain_tmr_reg == TMR_LAST) begin
                        // Give up on the slave: drop the held command and forget owed reads.
                        state_reg         <= FROZEN;
                        freeze_ack_reg    <= 1'b1;
                        drain_timeout_reg <= 1'b1;
                        cmd_valid_reg     <= 1'b0;
                        outstanding_reg   <= '0;
                    end
                end
                FROZEN: begin
                    if (!freeze_req) begin
                        state_reg      <= RUN;
                        freeze_ack_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= RUN;
                    freeze_ack_reg <= 1'b0;
                end
            endcase
        end
    end

    assign avmm_master_read      = cmd_valid_reg & cmd_rd_reg;
    assign avmm_master_write     = cmd_valid_reg & cmd_wr_reg;
    assign avmm_master_address   = cmd_addr_reg;
    assign avmm_master_writedata = cmd_data_reg;
    assign pr_readdata           = pr_readdata_reg;
    assign pr_readdatavalid      = pr_readdatavalid_reg;
    assign freeze_ack            = freeze_ack_reg;
    assign outstanding           = outstanding_reg;
    assign drain_timeout         = drain_timeout_reg;
    assign stray_resp_cnt        = stray_cnt_reg;

endmodule

// File: tb/tb_pr_sector_avmm_freeze_bridge.sv
// Scenario bench for pr_sector_avmm_freeze_bridge: directed freeze/limit/reset cases plus
// randomized traffic against a transaction-level queue model.
module tb_pr_sector_avmm_freeze_bridge;

    localparam int DW   = 32;
    localparam int AW   = 20;
    localparam int MAXO = 4;
    localparam int TO   = 16;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze_req = 1'b0;
    logic          freeze_ack;
    logic          pr_read = 1'b0;
    logic          pr_write = 1'b0;
    logic [AW-1:0] pr_address = '0;
    logic [DW-1:0] pr_writedata = '0;
    logic          pr_waitrequest;
    logic [DW-1:0] pr_readdata;
    logic          pr_readdatavalid;
    logic          m_read;
    logic          m_write;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic          m_wait = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rvalid = 1'b0;
    logic [CW-1:0] outstanding;
    logic          drain_timeout;
    logic [7:0]    stray_resp_cnt;

    int total = 0;
    int bad = 0;
    int exp_stray = 0;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t          cmd_q[$];
    logic [AW-1:0] slave_q[$];

    pr_sector_avmm_freeze_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .freeze_req(freeze_req), .freeze_ack(freeze_ack),
        .pr_read(pr_read), .pr_write(pr_write), .pr_address(pr_address),
        .pr_writedata(pr_writedata), .pr_waitrequest(pr_waitrequest),
        .pr_readdata(pr_readdata), .pr_readdatavalid(pr_readdatavalid),
        .avmm_master_read(m_read), .avmm_master_write(m_write),
        .avmm_master_address(m_address), .avmm_master_writedata(m_writedata),
        .avmm_master_waitrequest(m_wait), .avmm_master_readdata(m_rdata),
        .avmm_master_readdatavalid(m_rvalid), .outstanding(outstanding),
        .drain_timeout(drain_timeout), .stray_resp_cnt(stray_resp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return {a[11:0], a} ^ 32'h5A5A_1234;
    endfunction

    task automatic test_reset();
        rst = 1'b1; pr_read = 1'b1;
        repeat (2) tick();
        total++; if (pr_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_wait: got %0b want 1", pr_waitrequest); end
        total++; if ({m_read, m_write, m_address, m_writedata} !== '0) begin bad++; $display("FAIL reset_master: got rd=%0b wr=%0b addr=%05h wd=%08h want 0", m_read, m_write, m_address, m_writedata); end
        total++; if ({pr_readdatavalid, pr_readdata, freeze_ack} !== '0) begin bad++; $display("FAIL reset_region: got rdv=%0b rd=%08h ack=%0b want 0", pr_readdatavalid, pr_readdata, freeze_ack); end
        total++; if ({outstanding, drain_timeout, stray_resp_cnt} !== '0) begin bad++; $display("FAIL reset_status: got out=%0d to=%0b stray=%0d want 0", outstanding, drain_timeout, stray_resp_cnt); end
        pr_read = 1'b0; rst = 1'b0; exp_stray = 0;
        tick();
        total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_release_wait: got %0b want 0", pr_waitrequest); end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        pr_write = 1'b1; pr_address = 20'h00010; pr_writedata = 32'hDEADBEEF;
        #1;
        total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_accept: got wait=%0b want 0", pr_waitrequest); end
        tick(); pr_write = 1'b0;
        total++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 20'h00010 || m_writedata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_issue: got wr=%0b rd=%0b addr=%05h wd=%08h want wr=1 rd=0 addr=00010 wd=deadbeef", m_write, m_read, m_address, m_writedata);
        end
        $display("write addr=00010 data=deadbeef");
        a = AW'($urandom); pr_read = 1'b1; pr_address = a;
        tick(); pr_read = 1'b0;
        total++; if (m_read !== 1'b1 || m_address !== a || outstanding !== CW'(1)) begin
            bad++; $display("FAIL rd_issue: got rd=%0b addr=%05h out=%0d want rd=1 addr=%05h out=1", m_read, m_address, outstanding, a);
        end
        tick();
        total++; if (m_read !== 1'b0) begin bad++; $display("FAIL rd_consumed: got rd=%0b want 0", m_read); end
        repeat (2) tick();
        d = $urandom; m_rdata = d; m_rvalid = 1'b1;
        tick(); m_rvalid = 1'b0;
        total++; if (pr_readdatavalid !== 1'b1 || pr_readdata !== d || outstanding !== '0) begin
            bad++; $display("FAIL rd_resp: got rdv=%0b data=%08h out=%0d want rdv=1 data=%08h out=0", pr_readdatavalid, pr_readdata, outstanding, d);
        end
        tick();
        total++; if (pr_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_resp_pulse: got rdv=%0b want 0", pr_readdatavalid); end
        $display("read addr=%05h data=%08h", a, d);
    endtask

    task automatic test_outstanding_limit();
        logic [DW-1:0] d;
        m_wait = 1'b0; pr_read = 1'b1;
        for (int i = 0; i < MAXO; i++) begin
            pr_address = AW'($urandom);
            #1;
            total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL limit_accept %0d: got wait=%0b want 0", i, pr_waitrequest); end
            tick();
        end
        total++; if (outstanding !== CW'(MAXO) || pr_waitrequest !== 1'b1) begin
            bad++; $display("FAIL limit_full: got out=%0d wait=%0b want out=%0d wait=1", outstanding, pr_waitrequest, MAXO);
        end
        pr_read = 1'b0; pr_write = 1'b1; pr_writedata = $urandom;
        #1;
        total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL limit_write_ok: got wait=%0b want 0", pr_waitrequest); end
        tick(); pr_write = 1'b0; pr_read = 1'b1;
        d = $urandom; m_rdata = d; m_rvalid = 1'b1;
        #1;
        total++; if (pr_waitrequest !== 1'b1) begin bad++; $display("FAIL limit_stall: got wait=%0b want 1", pr_waitrequest); end
        tick(); m_rvalid = 1'b0;
        total++; if (outstanding !== CW'(MAXO - 1) || pr_readdatavalid !== 1'b1 || pr_readdata !== d) begin
            bad++; $display("FAIL limit_resp: got out=%0d rdv=%0b data=%08h want out=%0d rdv=1 data=%08h", outstanding, pr_readdatavalid, pr_readdata, MAXO - 1, d);
        end
        #1;
        total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL limit_reaccept: got wait=%0b want 0", pr_waitrequest); end
        tick(); pr_read = 1'b0;
        total++; if (outstanding !== CW'(MAXO) || m_read !== 1'b1) begin
            bad++; $display("FAIL limit_fifth: got out=%0d rd=%0b want out=%0d rd=1", outstanding, m_read, MAXO);
        end
        m_rvalid = 1'b1;
        repeat (MAXO) tick();
        m_rvalid = 1'b0;
        total++; if (outstanding !== '0) begin bad++; $display("FAIL limit_flush: got out=%0d want 0", outstanding); end
        $display("outstanding limit sequence done");
    endtask

    task automatic test_freeze_drain();
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        d1 = $urandom; d2 = $urandom;
        m_wait = 1'b0; pr_read = 1'b1; pr_address = AW'($urandom);
        tick(); pr_address = AW'($urandom);
        tick(); pr_read = 1'b0; freeze_req = 1'b1;
        tick();
        pr_write = 1'b1; pr_address = AW'($urandom); pr_writedata = $urandom;
        #1;
        total++; if (pr_waitrequest !== 1'b1 || freeze_ack !== 1'b0 || outstanding !== CW'(2)) begin
            bad++; $display("FAIL drain_enter: got wait=%0b ack=%0b out=%0d want wait=1 ack=0 out=2", pr_waitrequest, freeze_ack, outstanding);
        end
        repeat (2) tick();
        m_rdata = d1; m_rvalid = 1'b1;
        tick(); m_rvalid = 1'b0;
        total++; if (pr_readdatavalid !== 1'b1 || pr_readdata !== d1 || freeze_ack !== 1'b0) begin
            bad++; $display("FAIL drain_resp1: got rdv=%0b data=%08h ack=%0b want rdv=1 data=%08h ack=0", pr_readdatavalid, pr_readdata, freeze_ack, d1);
        end
        repeat (2) tick();
        total++; if (freeze_ack !== 1'b0) begin bad++; $display("FAIL drain_ack_early: got ack=%0b want 0", freeze_ack); end
        m_rdata = d2; m_rvalid = 1'b1;
        tick(); m_rvalid = 1'b0;
        total++; if (pr_readdatavalid !== 1'b1 || pr_readdata !== d2 || freeze_ack !== 1'b1 || outstanding !== '0) begin
            bad++; $display("FAIL drain_resp2: got rdv=%0b data=%08h ack=%0b out=%0d want rdv=1 data=%08h ack=1 out=0", pr_readdatavalid, pr_readdata, freeze_ack, outstanding, d2);
        end
        tick();
        total++; if (freeze_ack !== 1'b1 || m_write !== 1'b0 || pr_waitrequest !== 1'b1) begin
            bad++; $display("FAIL frozen_hold: got ack=%0b wr=%0b wait=%0b want ack=1 wr=0 wait=1", freeze_ack, m_write, pr_waitrequest);
        end
        pr_write = 1'b0; freeze_req = 1'b0;
        tick();
        total++; if (freeze_ack !== 1'b0 || pr_waitrequest !== 1'b0) begin
            bad++; $display("FAIL unfreeze: got ack=%0b wait=%0b want ack=0 wait=0", freeze_ack, pr_waitrequest);
        end
        $display("freeze with two reads in flight done");
    endtask

    task automatic test_drain_timeout();
        m_wait = 1'b0; pr_read = 1'b1; pr_address = AW'($urandom);
        tick(); pr_read = 1'b0; freeze_req = 1'b1;
        tick();
        for (int i = 0; i < TO; i++) begin
            total++; if (freeze_ack !== 1'b0 || drain_timeout !== 1'b0) begin
                bad++; $display("FAIL timeout_early %0d: got ack=%0b to=%0b want 0 0", i, freeze_ack, drain_timeout);
            end
            tick();
        end
        total++; if (freeze_ack !== 1'b1 || drain_timeout !== 1'b1 || outstanding !== '0) begin
            bad++; $display("FAIL timeout_frozen: got ack=%0b to=%0b out=%0d want ack=1 to=1 out=0", freeze_ack, drain_timeout, outstanding);
        end
        m_rdata = $urandom; m_rvalid = 1'b1;
        tick(); m_rvalid = 1'b0; exp_stray++;
        total++; if (pr_readdatavalid !== 1'b0 || stray_resp_cnt !== 8'(exp_stray)) begin
            bad++; $display("FAIL timeout_stray: got rdv=%0b stray=%0d want rdv=0 stray=%0d", pr_readdatavalid, stray_resp_cnt, exp_stray);
        end
        freeze_req = 1'b0;
        tick();
        total++; if (freeze_ack !== 1'b0 || drain_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky: got ack=%0b to=%0b want ack=0 to=1", freeze_ack, drain_timeout);
        end
        $display("drain timeout done");
    endtask

    task automatic test_random_traffic();
        cmd_t          c;
        int            mout;
        bit            exp_rv;
        bit            resp;
        bit            active;
        bit            pred_wait;
        logic [DW-1:0] exp_rd;
        mout = 0; exp_rv = 1'b0; exp_rd = '0;
        cmd_q.delete(); slave_q.delete();
        for (int i = 0; i < 400; i++) begin
            total++; if (pr_readdatavalid !== exp_rv || (exp_rv && pr_readdata !== exp_rd)) begin
                bad++; $display("FAIL rnd_resp cyc %0d: got rdv=%0b data=%08h want rdv=%0b data=%08h", i, pr_readdatavalid, pr_readdata, exp_rv, exp_rd);
            end
            total++; if (outstanding !== CW'(mout)) begin
                bad++; $display("FAIL rnd_outstanding cyc %0d: got %0d want %0d", i, outstanding, mout);
            end
            if (cmd_q.size() > 0) begin
                c = cmd_q[0];
                total++; if (m_read !== c.rd || m_write !== !c.rd || m_address !== c.addr || (!c.rd && m_writedata !== c.data)) begin
                    bad++; $display("FAIL rnd_cmd cyc %0d: got rd=%0b wr=%0b addr=%05h wd=%08h want rd=%0b addr=%05h wd=%08h", i, m_read, m_write, m_address, m_writedata, c.rd, c.addr, c.data);
                end
            end else begin
                total++; if (m_read !== 1'b0 || m_write !== 1'b0) begin
                    bad++; $display("FAIL rnd_idle cyc %0d: got rd=%0b wr=%0b want 0 0", i, m_read, m_write);
                end
            end

            active = (i < 350);
            pr_read = active && ($urandom_range(0, 99) < 40);
            pr_write = active && ($urandom_range(0, 99) < 30);
            pr_address = AW'($urandom); pr_writedata = $urandom;
            m_wait = ($urandom_range(0, 99) < 30);
            resp = (slave_q.size() > 0) && (!active || $urandom_range(0, 99) < 35);
            m_rvalid = resp;
            m_rdata = resp ? rd_fn(slave_q[0]) : $urandom;
            #1;
            pred_wait = ((cmd_q.size() > 0) && m_wait) || (pr_read && mout == MAXO);
            total++; if (pr_waitrequest !== pred_wait) begin
                bad++; $display("FAIL rnd_wait cyc %0d: got %0b want %0b", i, pr_waitrequest, pred_wait);
            end

            exp_rv = resp;
            if (resp) begin
                exp_rd = rd_fn(slave_q.pop_front());
                mout--;
            end
            if (cmd_q.size() > 0 && !m_wait) begin
                c = cmd_q.pop_front();
                if (c.rd) slave_q.push_back(c.addr);
            end
            if ((pr_read || pr_write) && !pred_wait) begin
                c.rd = pr_read; c.addr = pr_address; c.data = pr_writedata;
                cmd_q.push_back(c);
                if (pr_read) mout++;
                $display("rnd %0d: %s addr=%05h", i, pr_read ? "read" : "write", pr_address);
            end
            tick();
        end
        pr_read = 1'b0; pr_write = 1'b0; m_rvalid = 1'b0; m_wait = 1'b0;
        tick();
        total++; if (outstanding !== '0 || mout != 0 || stray_resp_cnt !== 8'(exp_stray)) begin
            bad++; $display("FAIL rnd_flush: got out=%0d model=%0d stray=%0d want 0 0 %0d", outstanding, mout, stray_resp_cnt, exp_stray);
        end
    endtask

    task automatic test_abort_reset();
        m_wait = 1'b1; pr_write = 1'b1; pr_address = AW'($urandom); pr_writedata = $urandom;
        #1;
        total++; if (pr_waitrequest !== 1'b0) begin bad++; $display("FAIL abort_accept: got wait=%0b want 0", pr_waitrequest); end
        tick(); pr_write = 1'b0; freeze_req = 1'b1;
        tick(); freeze_req = 1'b0;
        #1;
        total++; if (pr_waitrequest !== 1'b1 || m_write !== 1'b1 || freeze_ack !== 1'b0) begin
            bad++; $display("FAIL abort_drain: got wait=%0b wr=%0b ack=%0b want 1 1 0", pr_waitrequest, m_write, freeze_ack);
        end
        tick();
        m_wait = 1'b0;
        #1;
        total++; if (pr_waitrequest !== 1'b0 || freeze_ack !== 1'b0 || m_write !== 1'b1) begin
            bad++; $display("FAIL abort_run: got wait=%0b ack=%0b wr=%0b want 0 0 1", pr_waitrequest, freeze_ack, m_write);
        end
        tick();
        total++; if (m_write !== 1'b0 || freeze_ack !== 1'b0) begin
            bad++; $display("FAIL abort_consumed: got wr=%0b ack=%0b want 0 0", m_write, freeze_ack);
        end
        $display("freeze abort done");

        pr_read = 1'b1; pr_address = AW'($urandom);
        tick(); pr_address = AW'($urandom);
        tick();
        rst = 1'b1;
        #1;
        total++; if (pr_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait: got %0b want 1", pr_waitrequest); end
        tick();
        total++; if ({m_read, m_write, m_address, m_writedata, pr_readdatavalid, pr_readdata, freeze_ack} !== '0
                     || {outstanding, drain_timeout, stray_resp_cnt} !== '0) begin
            bad++; $display("FAIL rst_mid: got rd=%0b wr=%0b out=%0d to=%0b stray=%0d ack=%0b want all 0", m_read, m_write, outstanding, drain_timeout, stray_resp_cnt, freeze_ack);
        end
        rst = 1'b0; pr_read = 1'b0; exp_stray = 0;
        m_rdata = $urandom; m_rvalid = 1'b1;
        tick(); m_rvalid = 1'b0; exp_stray++;
        total++; if (pr_readdatavalid !== 1'b0 || stray_resp_cnt !== 8'(exp_stray)) begin
            bad++; $display("FAIL rst_stray: got rdv=%0b stray=%0d want rdv=0 stray=%0d", pr_readdatavalid, stray_resp_cnt, exp_stray);
        end
        $display("reset mid-burst done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_outstanding_limit();
        test_freeze_drain();
        test_drain_timeout();
        test_random_traffic();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pr_sector_avmm_freeze_bridge.md
# pr_sector_avmm_freeze_bridge

Parametrised Avalon-MM bridge between a partially reconfigurable sector's user-logic AVMM master and the static NoC AVMM slave port. It registers the command path, tracks outstanding reads, and implements a freeze handshake. The handshake drains in-flight traffic, then isolates the region during reconfiguration so that stray or garbage region outputs never reach the static fabric. One instance sits in each sector wrapper, replacing direct pass-through of the user-logic AVMM signals.

## Interface
- DATA_W, 32, AVMM data width.
- ADDR_W, 20, AVMM address width.
- MAX_OUTSTANDING, 4, maximum reads accepted without a returned response (1..15).
- TIMEOUT_CYCLES, 1024, DRAIN cycles before the bridge forces FROZEN (≥2).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of `outstanding`.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- freeze_req  in  1  level request from the PR controller to isolate the region.
- freeze_ack  out  1  high while the region is isolated (FROZEN).
- pr_read / pr_write  in  1  region-side command strobes.
- pr_address  in  ADDR_W  region-side address.
- pr_writedata  in  DATA_W  region-side write data.
- pr_waitrequest  out  1  region-side stall.
- pr_readdata  out  DATA_W  region-side read data.
- pr_readdatavalid  out  1  region-side read data valid.
- avmm_master_read / avmm_master_write  out  1  static-side command strobes (registered).
- avmm_master_address  out  ADDR_W  static-side address (registered).
- avmm_master_writedata  out  DATA_W  static-side write data (registered).
- avmm_master_waitrequest  in  1  static-side stall.
- avmm_master_readdata  in  DATA_W  static-side read data.
- avmm_master_readdatavalid  in  1  static-side read data valid.
- outstanding  out  CNT_W  current count of reads not yet responded.
- drain_timeout  out  1  sticky flag: DRAIN was forced to FROZEN by timeout.
- stray_resp_cnt  out  8  saturating count of readdatavalid pulses arriving with `outstanding`==0.

## Operation
- State machine has three states: RUN, DRAIN and FROZEN. Reset state is RUN.
- One-entry command register (cmd_valid, rd, wr, addr, data) drives all avmm_master_* outputs. avmm_master_read = cmd_valid & rd; avmm_master_write = cmd_valid & wr.
- pr_waitrequest (combinational) = rst | (state!=RUN) | (cmd_valid & avmm_master_waitrequest) | (pr_read & outstanding==MAX_OUTSTANDING).
- Accept means (pr_read|pr_write) & !pr_waitrequest. An accept loads the register and sets cmd_valid.
  - If pr_read and pr_write are both high, it is treated as a read.
- Consume means cmd_valid & !avmm_master_waitrequest. cmd_valid clears unless an accept occurs in the same cycle, in which case the register reloads.
- `outstanding` increments on a read accept and decrements on avmm_master_readdatavalid. Both in the same cycle leaves it unchanged. It never underflows.
  - A response arriving with outstanding==0 increments stray_resp_cnt (saturates at 255) and is not forwarded.
- Transitions:
  - RUN→DRAIN when freeze_req=1.
  - DRAIN→FROZEN when cmd_valid==0 and outstanding==0. The register still issues its held command until consumed. No new accepts.
  - DRAIN→RUN when freeze_req drops before drain completes; the freeze is aborted and freeze_ack never asserts.
  - DRAIN→FROZEN when TIMEOUT_CYCLES have elapsed in DRAIN. This sets drain_timeout, clears cmd_valid and zeroes outstanding.
  - FROZEN→RUN when freeze_req=0.
- In FROZEN: freeze_ack=1, no accepts, pr_readdatavalid forced 0, and any readdatavalid counts as stray.
- drain_timeout and stray_resp_cnt clear only on rst.

## Timing
- Reset values:
  - All avmm_master_* outputs, pr_readdata, pr_readdatavalid, freeze_ack, outstanding, drain_timeout and stray_resp_cnt are 0.
  - pr_waitrequest is 1 while rst is high.
- Command latency: accept at cycle N gives the avmm_master_* command visible at N+1. Back-to-back accepts sustain 1 command/cycle while avmm_master_waitrequest=0.
- Response latency: avmm_master_readdatavalid at M gives pr_readdatavalid/pr_readdata at M+1. Responses pass in order with no buffering.
- freeze_req is sampled at the clock edge. An accept is still possible in the cycle freeze_req first rises, because state is still RUN.
- Idle freeze: freeze_req high at N gives DRAIN at N+1 and FROZEN with freeze_ack=1 at N+2.
- Unfreeze: freeze_req low at N gives RUN at N+1, with freeze_ack=0 and accepts possible at N+1.
- rst mid-operation returns to RUN at the next cycle with all state cleared. In-flight responses after reset count as stray.

## Test plan
- Write then read, no stall: pr_write addr 0x00010 data 0xDEADBEEF at cycle 5 gives avmm_master_write at cycle 6. A read with response at cycle 10 gives pr_readdatavalid at cycle 11 with matching data.
- Outstanding limit: slave withholds responses; 4 reads accepted, the 5th sees pr_waitrequest=1 and `outstanding`=4. One response arrives, and the 5th read is accepted the next cycle.
- Freeze with 2 reads in flight: freeze_req high gives DRAIN. Responses at +3 and +6 are forwarded, and freeze_ack rises 1 cycle after the second response. pr_write during DRAIN is stalled.
- Drain timeout with TIMEOUT_CYCLES=16: 1 read never answered; FROZEN is entered 16 cycles after DRAIN, drain_timeout=1 and outstanding=0. A late response increments stray_resp_cnt to 1 and is not forwarded.
- Abort and reset: freeze_req pulses for 1 cycle with a stalled write, giving DRAIN then RUN with freeze_ack never asserted. rst asserted mid-burst sets all outputs to reset values the next cycle.
